// File: rtl/mux4_rr_arbiter_pkg.sv
// mux4_rr_arbiter_pkg: shared constants and state encoding for the mux4 round-robin arbiter
package mux4_rr_arbiter_pkg;
    localparam int NUM_REQ      = 4;
    localparam int DEF_MAX_HOLD = 8;
    typedef enum logic {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_t;
endpackage

// File: rtl/rr_pick4.sv
// rr_pick4: rotating-priority pick of one of four requests, scan starts just after last
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] last,
    output logic [1:0] idx,
    output logic       any
);
    logic [1:0] c1, c2, c3, c4;
    always_comb begin
        c1  = last + 2'd1;
        c2  = last + 2'd2;
        c3  = last + 2'd3;
        c4  = last;
        idx = req[c1] ? c1 : req[c2] ? c2 : req[c3] ? c3 : c4;
        any = |req;
    end
endmodule

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin owner of a shared 4:1 mux with bounded hold time
// and a dead cycle between owners so the mux output is never sampled mid-switch.
module mux4_rr_arbiter
    import mux4_rr_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = DEF_MAX_HOLD,
    parameter int CNT_W    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic               select1,
    output logic               select2,
    output logic               valid,
    output logic               busy
);
    state_t           state;
    logic [CNT_W-1:0] hold_cnt;
    logic [1:0]       last;
    logic [1:0]       idx;
    logic             any;
    logic [1:0]       owner;
    logic             at_limit;
    logic             release_now;

    rr_pick4 u_pick (
        .req  (req),
        .last (last),
        .idx  (idx),
        .any  (any)
    );

    // The select lines are only rewritten on a new grant, so they name the owner.
    always_comb begin
        owner       = {select2, select1};
        at_limit    = hold_cnt == CNT_W'(MAX_HOLD - 1);
        release_now = !req[owner] || (at_limit && |(req & ~grant));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            grant    <= '0;
            select1  <= 1'b0;
            select2  <= 1'b0;
            valid    <= 1'b0;
            busy     <= 1'b0;
            hold_cnt <= '0;
            last     <= 2'd3;
        end else if (state == ST_IDLE) begin
            if (any) begin
                state    <= ST_GRANT;
                grant    <= 4'b0001 << idx;
                select1  <= idx[0];
                select2  <= idx[1];
                valid    <= 1'b1;
                busy     <= 1'b1;
                hold_cnt <= '0;
            end
        end else if (release_now) begin
            state <= ST_IDLE;
            grant <= '0;
            valid <= 1'b0;
            busy  <= 1'b0;
            last  <= owner;
        end else if (!at_limit) begin
            hold_cnt <= hold_cnt + CNT_W'(1);
        end
    end
endmodule
